tap_data_regs: RTL and testbench
================================

# tap_data_regs

JTAG instruction and data register bank that sits directly downstream of the TAP controller. It consumes the controller's 4-bit `STATE` together with `TDI`, and implements the instruction register (IR) and three data registers: BYPASS, IDCODE and an 8-bit USER scan register. It produces `TDO` and `TDO_EN` for the chip pin, plus a parallel USER output for core logic.

## Interface
- `IR_WIDTH`, default 4: instruction register width; minimum 2.
- `USER_WIDTH`, default 8: USER data register width.
- `IDCODE_VALUE`, default 32'h1234_5001: device ID. Bit 0 must be 1.
- `TCK` input 1: test clock, the single clock. Logic uses the rising edge, except `TDO` and `TDO_EN`, which use the falling edge.
- `TRST` input 1: reset, asynchronous, active-high.
- `STATE` input 4: registered TAP state from the controller, using the encoding in `tap_pkg`.
- `TDI` input 1: serial test data in.
- `USER_IN` input USER_WIDTH: parallel value captured into the USER register.
- `TDO` output 1: serial test data out.
- `TDO_EN` output 1: TDO pad enable; high only while shifting.
- `IR_OUT` output IR_WIDTH: current (updated) instruction.
- `USER_OUT` output USER_WIDTH: USER register update latch.
- `USER_UPDATE` output 1: one-cycle pulse when `USER_OUT` is written.

## Operation
- State encoding:
  - TLR=F, RTI=C
  - SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5
  - SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D
- Opcodes:
  - IDCODE = 4'h1
  - USER = 4'h2
  - BYPASS = 4'hF
  - Any other code selects BYPASS.
- Reset values (TRST high), all applied immediately:
  - `IR_OUT`=IDCODE (4'h1), IR shift reg=0, DR shift reg=0, bypass=0
  - `USER_OUT`=0, `USER_UPDATE`=0, `TDO`=0, `TDO_EN`=0
- STATE==TLR: on each rising edge, `IR_OUT` is loaded with IDCODE. This is synchronous; `USER_OUT` is unaffected.
- IR path:
  - CAP_IR: IR shift reg <= {0…,2'b01}.
  - SH_IR: shift right; `TDI` enters the MSB.
  - UPD_IR: `IR_OUT` <= IR shift reg.
- DR path (selected by `IR_OUT`):
  - CAP_DR: IDCODE loads `IDCODE_VALUE`; USER loads `USER_IN`; BYPASS loads 0.
  - SH_DR: the selected register shifts right, LSB first, with `TDI` entering the MSB. BYPASS is a 1-bit register.
  - UPD_DR with USER selected: `USER_OUT` <= USER shift reg and `USER_UPDATE`=1 for exactly one TCK cycle. No effect for other instructions.
- Pause/Exit states hold all shift registers unchanged.
- Falling edge:
  - `TDO` <= LSB of the IR shift reg when STATE==SH_IR, or of the selected DR when STATE==SH_DR; otherwise it holds its last value.
  - `TDO_EN` <= (STATE==SH_IR || STATE==SH_DR).
- `IR_OUT` changes only in UPD_IR or TLR, never during shifting.

## Timing
- Capture and update take effect at the rising edge that ends the CAP or UPD state.
- First TDO bit (bit 0 of the captured value) appears at the falling edge of the first SH cycle. The host samples it at the next rising edge.
- N shift cycles move N bits. BYPASS delays `TDI` by exactly one TCK.
- `USER_UPDATE` is asserted from the rising edge leaving UPD_DR to the next rising edge.
- If TRST is asserted mid-shift, all state is cleared within the same cycle, and any partially shifted data is discarded. After release, the controller's TLR keeps `IR_OUT`=IDCODE.
- Simultaneous UPD_IR and TLR cannot occur because the states are exclusive.

## Structure
- `tap_pkg` holds the 16 state encodings, the opcode constants and the IR capture pattern. The TAP controller and this block both import it.
- Sub-module `tap_shift_reg` (params WIDTH, RESET_VAL) provides parallel load, shift-right and hold, with async TRST. It is instantiated for the IR, IDCODE and USER registers; BYPASS is a single flop in the top level.
- TDO mux and negedge output flops are in the top level.

## Test plan
- Reset then idle: TRST=1 for 2 cycles → `IR_OUT`=1, `TDO_EN`=0, `USER_OUT`=00. Five TMS=1 cycles into TLR leave `IR_OUT`=1.
- IDCODE read: after reset, walk to SH_DR and shift 32 cycles with TDI=0 → TDO stream, LSB first, equals 32'h1234_5001. `TDO_EN`=1 only during those 32 cycles.
- IR scan: shift 4'h2 into the IR → TDO emits 1,0,0,0 (capture pattern). `IR_OUT` stays 1 until UPD_IR, then becomes 2.
- USER write/read: with IR=USER, `USER_IN`=8'hA5, shift in 8'h3C → TDO emits A5 LSB first. At UPD_DR, `USER_OUT`=3C and `USER_UPDATE` pulses exactly once.
- Bypass and unknown code: load IR=4'h7 and shift TDI=1,0,1,1 → TDO emits 0,1,0,1 (one-cycle delay).
- Mid-shift reset: assert TRST during the 10th IDCODE shift cycle → `TDO`=0, `TDO_EN`=0, `IR_OUT`=1 immediately. A subsequent full IDCODE read is correct.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared JTAG TAP definitions: controller state encoding, instruction opcodes
// and the fixed IR capture pattern.
package tap_pkg;

    typedef enum logic [3:0] {
        EX2_DR = 4'h0,
        EX1_DR = 4'h1,
        SH_DR  = 4'h2,
        PAU_DR = 4'h3,
        SEL_IR = 4'h4,
        UPD_DR = 4'h5,
        CAP_DR = 4'h6,
        SEL_DR = 4'h7,
        EX2_IR = 4'h8,
        EX1_IR = 4'h9,
        SH_IR  = 4'hA,
        PAU_IR = 4'hB,
        RTI    = 4'hC,
        UPD_IR = 4'hD,
        CAP_IR = 4'hE,
        TLR    = 4'hF
    } tap_state_e;

    localparam logic [3:0] OP_IDCODE  = 4'h1;
    localparam logic [3:0] OP_USER    = 4'h2;
    localparam logic [3:0] OP_BYPASS  = 4'hF;

    // Low two IR bits must read back 2'b01 on capture.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/tap_shift_reg.sv
// Scan register with parallel load, shift-right (serial in at MSB) and hold.
// Load/shift take effect on the rising clock edge; no backpressure, shift-enable paced.
module tap_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] shifted;

    if (WIDTH == 1) begin : g_one
        assign shifted = sin_i;
    end else begin : g_multi
        assign shifted = {sin_i, sr_q[WIDTH-1:1]};
    end

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_dat_i;
        end else if (shift_i) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q <= RESET_VAL;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q;

endmodule

// File: rtl/tap_data_regs.sv
// JTAG IR plus BYPASS/IDCODE/USER data registers behind the TAP controller.
// Capture/update on TCK rise, TDO/TDO_EN launched on TCK fall; no backpressure.
module tap_data_regs
    import tap_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter int          USER_WIDTH   = 8,
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5001
) (
    input  logic                  TCK,
    input  logic                  TRST,
    input  logic [3:0]            STATE,
    input  logic                  TDI,
    input  logic [USER_WIDTH-1:0] USER_IN,
    output logic                  TDO,
    output logic                  TDO_EN,
    output logic [IR_WIDTH-1:0]   IR_OUT,
    output logic [USER_WIDTH-1:0] USER_OUT,
    output logic                  USER_UPDATE
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(OP_USER);
    localparam logic [IR_WIDTH-1:0] IR_CAP    = IR_WIDTH'(IR_CAPTURE);

    tap_state_e state;
    assign state = tap_state_e'(STATE);

    logic [IR_WIDTH-1:0]   ir_out_q, ir_out_d;
    logic [USER_WIDTH-1:0] user_out_q, user_out_d;
    logic                  user_update_q, user_update_d;
    logic                  bypass_q, bypass_d;
    logic                  tdo_q, tdo_d;
    logic                  tdo_en_q, tdo_en_d;

    logic [IR_WIDTH-1:0]   ir_sr;
    logic [31:0]           idcode_sr;
    logic [USER_WIDTH-1:0] user_sr;

    logic sel_idcode, sel_user, sel_bypass;
    assign sel_idcode = (ir_out_q == IR_IDCODE);
    assign sel_user   = (ir_out_q == IR_USER);
    assign sel_bypass = !sel_idcode && !sel_user;

    tap_shift_reg #(.WIDTH(IR_WIDTH), .RESET_VAL('0)) u_ir_sr (
        .clk_i      (TCK),
        .rst_i      (TRST),
        .load_i     (state == CAP_IR),
        .shift_i    (state == SH_IR),
        .load_dat_i (IR_CAP),
        .sin_i      (TDI),
        .q_o        (ir_sr)
    );

    tap_shift_reg #(.WIDTH(32), .RESET_VAL('0)) u_idcode_sr (
        .clk_i      (TCK),
        .rst_i      (TRST),
        .load_i     (state == CAP_DR && sel_idcode),
        .shift_i    (state == SH_DR && sel_idcode),
        .load_dat_i (IDCODE_VALUE),
        .sin_i      (TDI),
        .q_o        (idcode_sr)
    );

    tap_shift_reg #(.WIDTH(USER_WIDTH), .RESET_VAL('0)) u_user_sr (
        .clk_i      (TCK),
        .rst_i      (TRST),
        .load_i     (state == CAP_DR && sel_user),
        .shift_i    (state == SH_DR && sel_user),
        .load_dat_i (USER_IN),
        .sin_i      (TDI),
        .q_o        (user_sr)
    );

    // Only the serial end of the IDCODE register is ever observed.
    logic unused_idcode_hi;
    assign unused_idcode_hi = ^idcode_sr[31:1];

    always_comb begin
        ir_out_d      = ir_out_q;
        user_out_d    = user_out_q;
        user_update_d = 1'b0;
        bypass_d      = bypass_q;
        if (state == TLR) begin
            ir_out_d = IR_IDCODE;
        end else if (state == UPD_IR) begin
            ir_out_d = ir_sr;
        end
        if (state == UPD_DR && sel_user) begin
            user_out_d    = user_sr;
            user_update_d = 1'b1;
        end
        if (state == CAP_DR && sel_bypass) begin
            bypass_d = 1'b0;
        end else if (state == SH_DR && sel_bypass) begin
            bypass_d = TDI;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_out_q      <= IR_IDCODE;
            user_out_q    <= '0;
            user_update_q <= 1'b0;
            bypass_q      <= 1'b0;
        end else begin
            ir_out_q      <= ir_out_d;
            user_out_q    <= user_out_d;
            user_update_q <= user_update_d;
            bypass_q      <= bypass_d;
        end
    end

    // TDO holds its last bit outside shift states so the pad sees no glitch.
    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = (state == SH_IR) || (state == SH_DR);
        if (state == SH_IR) begin
            tdo_d = ir_sr[0];
        end else if (state == SH_DR) begin
            if (sel_idcode) begin
                tdo_d = idcode_sr[0];
            end else if (sel_user) begin
                tdo_d = user_sr[0];
            end else begin
                tdo_d = bypass_q;
            end
        end
    end

    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO         = tdo_q;
    assign TDO_EN      = tdo_en_q;
    assign IR_OUT      = ir_out_q;
    assign USER_OUT    = user_out_q;
    assign USER_UPDATE = user_update_q;

endmodule

// File: tb/tb_tap_data_regs.sv
// Randomized bench for tap_data_regs: drives TAP states directly and checks
// scan streams against a whole-scan arithmetic model of the register bank.
module tb_tap_data_regs;
    import tap_pkg::*;

    logic       TCK = 1'b0;
    logic       TRST;
    logic [3:0] STATE;
    logic       TDI;
    logic [7:0] USER_IN;
    logic       TDO;
    logic       TDO_EN;
    logic [3:0] IR_OUT;
    logic [7:0] USER_OUT;
    logic       USER_UPDATE;

    tap_data_regs dut (
        .TCK         (TCK),
        .TRST        (TRST),
        .STATE       (STATE),
        .TDI         (TDI),
        .USER_IN     (USER_IN),
        .TDO         (TDO),
        .TDO_EN      (TDO_EN),
        .IR_OUT      (IR_OUT),
        .USER_OUT    (USER_OUT),
        .USER_UPDATE (USER_UPDATE)
    );

    always #5 TCK = ~TCK;

    localparam logic [31:0] IDCODE_VAL = 32'h1234_5001;

    int         n_checks = 0;
    int         n_errors = 0;
    int         upd_cnt  = 0;
    logic [3:0] m_ir;
    logic [7:0] m_user;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One TCK cycle; entered and left just after a rising edge.
    task automatic tick(input tap_state_e st, input logic tdi, output logic tdo_s);
        STATE = st;
        TDI   = tdi;
        @(negedge TCK);
        #1;
        tdo_s = TDO;
        check("tdo_en", 64'(TDO_EN), 64'(st == SH_DR || st == SH_IR));
        check("ir_out", 64'(IR_OUT), 64'(m_ir));
        @(posedge TCK);
        #1;
        if (USER_UPDATE) upd_cnt++;
        if (st == TLR) m_ir = OP_IDCODE;
    endtask

    // Whole scan: out stream is the captured word followed by TDI; the register
    // ends up holding the window of that stream just past the shifted bits.
    task automatic scan(input bit is_ir, input int n, input logic [63:0] tdi_v,
                        input bit pause, input string tag);
        logic [63:0]  cap;
        int           w;
        bit           to_user;
        logic [127:0] comb;
        logic [127:0] fin;
        logic         o;
        logic         last;
        int           upd0;
        tap_state_e   cap_s, sh_s, ex1_s, pau_s, ex2_s, upd_s;

        to_user = 1'b0;
        if (is_ir) begin
            cap = 64'h1; w = 4;
            cap_s = CAP_IR; sh_s = SH_IR; ex1_s = EX1_IR;
            pau_s = PAU_IR; ex2_s = EX2_IR; upd_s = UPD_IR;
        end else begin
            cap_s = CAP_DR; sh_s = SH_DR; ex1_s = EX1_DR;
            pau_s = PAU_DR; ex2_s = EX2_DR; upd_s = UPD_DR;
            if (m_ir == OP_IDCODE) begin
                cap = 64'(IDCODE_VAL); w = 32;
            end else if (m_ir == OP_USER) begin
                cap = 64'(USER_IN); w = 8; to_user = 1'b1;
            end else begin
                cap = 64'h0; w = 1;
            end
        end
        comb = ({64'b0, tdi_v} << w) | {64'b0, cap};
        fin  = comb >> n;
        upd0 = upd_cnt;
        last = 1'b0;

        tick(SEL_DR, 1'b0, o);
        if (is_ir) tick(SEL_IR, 1'b0, o);
        tick(cap_s, 1'b0, o);
        for (int i = 0; i < n; i++) begin
            tick(sh_s, tdi_v[i], o);
            check({tag, "_tdo"}, 64'(o), 64'(comb[i]));
            last = o;
            if (pause && i == n / 2 && i < n - 1) begin
                tick(ex1_s, 1'b0, o);
                check({tag, "_hold_ex1"}, 64'(o), 64'(last));
                tick(pau_s, 1'b1, o);
                tick(pau_s, 1'b0, o);
                tick(ex2_s, 1'b1, o);
                check({tag, "_hold_ex2"}, 64'(o), 64'(last));
            end
        end
        tick(ex1_s, 1'b0, o);
        tick(upd_s, 1'b0, o);
        if (is_ir) m_ir = fin[3:0];
        if (to_user) m_user = fin[7:0];
        tick(RTI, 1'b0, o);
        tick(RTI, 1'b0, o);
        check({tag, "_user_out"}, 64'(USER_OUT), 64'(m_user));
        check({tag, "_upd_pulses"}, 64'(upd_cnt - upd0), 64'(to_user ? 1 : 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        o;
        logic [63:0] rv;
        int          n;
        logic [3:0]  ops [4];

        ops[0] = OP_IDCODE; ops[1] = OP_USER; ops[2] = OP_BYPASS; ops[3] = 4'h7;
        TRST = 1'b1; STATE = TLR; TDI = 1'b0; USER_IN = 8'h00;
        m_ir = OP_IDCODE; m_user = 8'h00;
        repeat (2) @(posedge TCK);
        #1;
        check("rst_ir_out", 64'(IR_OUT), 64'h1);
        check("rst_tdo_en", 64'(TDO_EN), 64'h0);
        check("rst_tdo", 64'(TDO), 64'h0);
        check("rst_user_out", 64'(USER_OUT), 64'h0);
        check("rst_user_upd", 64'(USER_UPDATE), 64'h0);
        TRST = 1'b0;
        repeat (5) tick(TLR, 1'b1, o);
        check("tlr_ir_out", 64'(IR_OUT), 64'h1);
        tick(RTI, 1'b0, o);

        scan(1'b0, 32, 64'h0, 1'b0, "idcode");
        scan(1'b1, 4, 64'h2, 1'b0, "ir_user");
        check("ir_is_user", 64'(IR_OUT), 64'h2);
        USER_IN = 8'hA5;
        scan(1'b0, 8, 64'h3C, 1'b0, "user");
        check("user_out_3c", 64'(USER_OUT), 64'h3C);
        scan(1'b1, 4, 64'h7, 1'b0, "ir_7");
        scan(1'b0, 4, 64'b1101, 1'b0, "bypass");

        // Reset partway into the 10th IDCODE shift cycle.
        scan(1'b1, 4, 64'h1, 1'b0, "ir_idcode");
        tick(SEL_DR, 1'b0, o);
        tick(CAP_DR, 1'b0, o);
        for (int i = 0; i < 9; i++) begin
            tick(SH_DR, 1'b0, o);
            check("pre_rst_tdo", 64'(o), 64'(IDCODE_VAL[i]));
        end
        STATE = SH_DR;
        @(negedge TCK);
        #1;
        TRST = 1'b1;
        #1;
        check("midrst_tdo", 64'(TDO), 64'h0);
        check("midrst_tdo_en", 64'(TDO_EN), 64'h0);
        check("midrst_ir_out", 64'(IR_OUT), 64'h1);
        check("midrst_user_out", 64'(USER_OUT), 64'h0);
        m_ir = OP_IDCODE; m_user = 8'h00;
        @(posedge TCK);
        #1;
        TRST = 1'b0;
        repeat (2) tick(TLR, 1'b1, o);
        tick(RTI, 1'b0, o);
        scan(1'b0, 32, 64'h0, 1'b0, "idcode_after_rst");

        for (int k = 0; k < 30; k++) begin
            rv = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1) begin
                scan(1'b1, 4, 64'(ops[$urandom_range(3, 0)]), 1'(k % 3 == 0), "rnd_ir");
            end else begin
                scan(1'b1, $urandom_range(10, 1), rv, 1'(k % 2), "rnd_ir_long");
            end
            USER_IN = 8'($urandom);
            rv = {$urandom, $urandom};
            n  = $urandom_range(40, 1);
            scan(1'b0, n, rv, 1'($urandom_range(1, 0)), "rnd_dr");
            if (k % 7 == 0) begin
                repeat (5) tick(TLR, 1'b1, o);
                tick(RTI, 1'b0, o);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
